// File: rtl/elevator_controller.sv
// Elevator car controller.
// Latches floor calls, sequences the car between floors and through door
// cycles using the plant's sensor feedback, tracks the current floor from
// arrival pulses and trips a sticky fault if a sensor event never arrives.
// The engine, door and fault outputs are registered, and each is computed from
// the state that is being entered. A command therefore changes on the same edge
// as the transition that calls for it.
module elevator_controller #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_WIDTH   = 3,
  parameter int DOOR_HOLD     = 20,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clock,
  input  logic                     an_reset,
  input  logic [BUTTONS_WIDTH-1:0] buttons,
  input  logic [1:0]               sensor_door,
  input  logic                     sensor_up,
  input  logic                     sensor_down,
  output logic [1:0]               engine,
  output logic [1:0]               door,
  output logic [FLOOR_WIDTH-1:0]   floor,
  output logic [BUTTONS_WIDTH-1:0] requests,
  output logic                     fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPENING,
    S_DOOR_OPEN,
    S_DOOR_CLOSING,
    S_FAULT
  } state_t;

  localparam logic [1:0] ENG_IDLE   = 2'd0;
  localparam logic [1:0] ENG_DOWN   = 2'd1;
  localparam logic [1:0] ENG_UP     = 2'd2;
  localparam logic [1:0] DOOR_IDLE  = 2'd0;
  localparam logic [1:0] DOOR_OPEN  = 2'd1;
  localparam logic [1:0] DOOR_CLOSE = 2'd2;
  localparam logic [1:0] SD_OPEN    = 2'd1;
  localparam logic [1:0] SD_CLOSED  = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(DOOR_HOLD + 1);

  localparam logic [WD_W-1:0]        WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(DOOR_HOLD - 1);
  localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR = FLOOR_WIDTH'(BUTTONS_WIDTH - 1);
  localparam logic [FLOOR_WIDTH-1:0] BOT_FLOOR = '0;

  state_t                     state_q, state_d;
  logic [1:0]                 engine_q, engine_d;
  logic [1:0]                 door_q, door_d;
  logic [FLOOR_WIDTH-1:0]     floor_q, floor_d;
  logic [BUTTONS_WIDTH-1:0]   req_q, req_d;
  logic                       fault_q, fault_d;
  logic                       dir_q, dir_d;
  logic [WD_W-1:0]            wd_q, wd_d;
  logic [HOLD_W-1:0]          hold_q, hold_d;
  logic                       sens_prev_q;

  // Derived decision terms
  logic                       moving;
  logic                       counting;
  logic                       arrival;
  logic [FLOOR_WIDTH-1:0]     floor_up;
  logic [FLOOR_WIDTH-1:0]     floor_dn;
  logic [BUTTONS_WIDTH-1:0]   here_mask;
  logic [BUTTONS_WIDTH-1:0]   req_live;
  logic                       any_above;
  logic                       any_below;

  // Helper terms: arrival edge, neighbour floors and pending calls above or below the car
  always_comb begin
    moving    = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    counting  = moving || (state_q == S_DOOR_OPENING) || (state_q == S_DOOR_CLOSING);
    arrival   = moving && (sensor_up || sensor_down) && !sens_prev_q;
    floor_up  = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FLOOR_WIDTH'(1);
    floor_dn  = (floor_q == BOT_FLOOR) ? floor_q : floor_q - FLOOR_WIDTH'(1);
    here_mask = BUTTONS_WIDTH'(1) << floor_q;
    // Calls latched this very cycle still count when deciding where to stop.
    req_live  = req_q | buttons;
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (i > int'(floor_q)) any_above = any_above | req_q[i];
      if (i < int'(floor_q)) any_below = any_below | req_q[i];
    end
  end

  // Next-state logic: FSM transitions, floor tracking, call latching, door hold and watchdog
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    req_d   = req_q | buttons;
    wd_d    = wd_q;

    case (state_q)
      S_IDLE: begin
        if (req_q[floor_q]) begin
          state_d = S_DOOR_OPENING;
        end else if (any_above && (dir_q == DIR_UP || !any_below)) begin
          state_d = S_MOVE_UP;
          dir_d   = DIR_UP;
        end else if (any_below) begin
          state_d = S_MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end

      S_MOVE_UP: begin
        if (arrival) begin
          floor_d = floor_up;
          if (req_live[floor_up] || floor_up == TOP_FLOOR) state_d = S_DOOR_OPENING;
        end
      end

      S_MOVE_DOWN: begin
        if (arrival) begin
          floor_d = floor_dn;
          if (req_live[floor_dn] || floor_dn == BOT_FLOOR) state_d = S_DOOR_OPENING;
        end
      end

      S_DOOR_OPENING: begin
        if (sensor_door == SD_OPEN) begin
          state_d = S_DOOR_OPEN;
          // The clear wins over a press of the same floor in this cycle.
          req_d   = req_live & ~here_mask;
          hold_d  = '0;
        end
      end

      S_DOOR_OPEN: begin
        // A press at the current floor keeps the door open rather than queueing a call.
        req_d = req_q | (buttons & ~here_mask);
        if (buttons[floor_q]) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_DOOR_CLOSING;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      S_DOOR_CLOSING: begin
        if (sensor_door == SD_CLOSED) state_d = S_IDLE;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A sensor event that never comes overrides any other transition.
    if (counting && wd_q == WD_LAST) state_d = S_FAULT;

    if (state_d != state_q || arrival) begin
      wd_d = '0;
    end else if (counting) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Output logic: commands decoded from the state being entered, fault is sticky
  always_comb begin
    engine_d = ENG_IDLE;
    door_d   = DOOR_IDLE;
    fault_d  = fault_q;
    case (state_d)
      S_MOVE_UP:      engine_d = ENG_UP;
      S_MOVE_DOWN:    engine_d = ENG_DOWN;
      S_DOOR_OPENING: door_d   = DOOR_OPEN;
      S_DOOR_CLOSING: door_d   = DOOR_CLOSE;
      S_FAULT:        fault_d  = 1'b1;
      default:        ;
    endcase
  end

  // State and output registers, cleared asynchronously to a parked car at floor 0
  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      state_q     <= S_IDLE;
      engine_q    <= ENG_IDLE;
      door_q      <= DOOR_IDLE;
      floor_q     <= '0;
      req_q       <= '0;
      fault_q     <= 1'b0;
      dir_q       <= DIR_UP;
      wd_q        <= '0;
      hold_q      <= '0;
      sens_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      engine_q    <= engine_d;
      door_q      <= door_d;
      floor_q     <= floor_d;
      req_q       <= req_d;
      fault_q     <= fault_d;
      dir_q       <= dir_d;
      wd_q        <= wd_d;
      hold_q      <= hold_d;
      sens_prev_q <= sensor_up | sensor_down;
    end
  end

  assign engine   = engine_q;
  assign door     = door_q;
  assign floor    = floor_q;
  assign requests = req_q;
  assign fault    = fault_q;

`ifndef SYNTHESIS
  // Safety invariants of the command outputs
  a_no_move_with_door : assert property (@(posedge clock) disable iff (!an_reset)
    !(engine_q != ENG_IDLE && door_q != DOOR_IDLE));
  a_no_up_at_top : assert property (@(posedge clock) disable iff (!an_reset)
    !(engine_q == ENG_UP && floor_q == TOP_FLOOR));
  a_no_down_at_bottom : assert property (@(posedge clock) disable iff (!an_reset)
    !(engine_q == ENG_DOWN && floor_q == BOT_FLOOR));
`endif

endmodule
